// File: rtl/ct_f_spsram_pkg.sv
// Shared types and default geometry for the parameterised single-port SRAM.
package ct_f_spsram_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 7;
  localparam int unsigned DEF_DATA_WIDTH = 144;

  // INIT runs the post-reset fill sweep; READY accepts user accesses.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ct_f_spsram_param_array.sv
// Single-port storage array: per-bit active-low write mask, read-first, registered read.
module ct_f_spsram_param_array #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 144
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic                  rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wmask_ni,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset; contents come only from writes.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= (mem_q[addr_i] & wmask_ni) | (wdata_i & ~wmask_ni);
    end
  end

  // Samples the pre-write word, so a write returns the old contents (read-first).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rd_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ct_f_spsram_param.sv
// SRAM wrapper: post-reset fill sweep with INIT_VALUE, user port gating, optional output register.
module ct_f_spsram_param
  import ct_f_spsram_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY,
  output state_t                dbg_state_o
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sweep_we;
  logic                  user_acc;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wmask_n;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Terminal entry is detected by equality with all-ones, never by a wrapped counter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sweep_we = 1'b0;
    case (state_q)
      INIT: begin
        sweep_we = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign BUSY        = (state_q == INIT);
  assign dbg_state_o = state_q;
  assign user_acc    = !CEN && !BUSY;

  // The sweep owns the array port while BUSY; user accesses are dropped then.
  assign arr_we      = sweep_we | (user_acc & ~GWEN);
  assign arr_addr    = BUSY ? cnt_q : A;
  assign arr_wdata   = BUSY ? INIT_VALUE : D;
  assign arr_wmask_n = BUSY ? '0 : WEN;

  ct_f_spsram_param_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk_i    (CLK),
    .rst_ni   (RST_B),
    .we_i     (arr_we),
    .rd_i     (user_acc),
    .addr_i   (arr_addr),
    .wmask_ni (arr_wmask_n),
    .wdata_i  (arr_wdata),
    .rdata_o  (arr_rdata)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd_vld_q;
      logic [DATA_WIDTH-1:0] out_q;

      // Output stage only advances on the cycle after an accepted read.
      always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
          rd_vld_q <= 1'b0;
          out_q    <= '0;
        end else begin
          rd_vld_q <= user_acc & GWEN;
          if (rd_vld_q) begin
            out_q <= arr_rdata;
          end
        end
      end

      assign Q = out_q;
    end else begin : g_no_out_reg
      assign Q = arr_rdata;
    end
  endgenerate

endmodule
